// File: rtl/mem_access_unit_if.sv
// Backing-memory bus between the load/store unit (master) and the memory (slave).
// The request is held until acknowledged; read data is sampled with the ack.
interface mem_access_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: alignment check, lane steering, load formatting and an
// ack timeout towards a single-outstanding backing memory.
//
// state | meaning
// IDLE  | waiting for a load/store request from the pipeline
// BUSY  | mem_req held, waiting for mem_ack or timeout
// DONE  | one-cycle completion; results pulse, pipeline released
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic [1:0]  MemWrite,
    input  logic [2:0]  LoadType,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        misalign,
    output logic        bus_err,
    mem_access_unit_if.master mem
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TC_LOAD = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} size_t;

    state_t      state_q;
    logic [CW-1:0] cnt_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_wdata_q;
    logic [1:0]  off_q;
    logic [2:0]  ltype_q;
    logic        is_read_q;
    logic [31:0] rdata_q;
    logic        rdata_valid_q;
    logic        misalign_q;
    logic        bus_err_q;

    logic        is_write;
    logic        req;
    logic        aligned;
    size_t       size_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [15:0] half_w;
    logic [7:0]  byte_w;
    logic [31:0] load_d;

    // Write wins over a simultaneous read; size comes from whichever op is taken.
    always_comb begin
        is_write = (MemWrite != 2'b00);
        req      = is_write || MemRead;
        size_d   = SZ_WORD;
        if (is_write) begin
            case (MemWrite)
                2'b10:   size_d = SZ_HALF;
                2'b11:   size_d = SZ_BYTE;
                default: size_d = SZ_WORD;
            endcase
        end else begin
            case (LoadType)
                3'b010, 3'b011, 3'b101: size_d = SZ_HALF;
                3'b100, 3'b110:         size_d = SZ_BYTE;
                default:                size_d = SZ_WORD;
            endcase
        end
        aligned = 1'b1;
        be_d    = 4'b1111;
        wdata_d = wdata;
        case (size_d)
            SZ_HALF: begin
                aligned = ~addr[0];
                be_d    = 4'b0011 << addr[1:0];
                wdata_d = {2{wdata[15:0]}};
            end
            SZ_BYTE: begin
                be_d    = 4'b0001 << addr[1:0];
                wdata_d = {4{wdata[7:0]}};
            end
            default: begin
                aligned = (addr[1:0] == 2'b00);
            end
        endcase
    end

    always_comb begin
        half_w = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (off_q)
            2'd1:    byte_w = mem.mem_rdata[15:8];
            2'd2:    byte_w = mem.mem_rdata[23:16];
            2'd3:    byte_w = mem.mem_rdata[31:24];
            default: byte_w = mem.mem_rdata[7:0];
        endcase
        case (ltype_q)
            3'b010:  load_d = {half_w, 16'h0000};
            3'b011:  load_d = {{16{half_w[15]}}, half_w};
            3'b101:  load_d = {16'h0000, half_w};
            3'b100:  load_d = {{24{byte_w[7]}}, byte_w};
            3'b110:  load_d = {24'h000000, byte_w};
            default: load_d = mem.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_be_q      <= '0;
            mem_wdata_q   <= '0;
            off_q         <= '0;
            ltype_q       <= '0;
            is_read_q     <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            rdata_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            bus_err_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (aligned) begin
                            state_q     <= BUSY;
                            cnt_q       <= TC_LOAD;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= is_write;
                            mem_addr_q  <= {addr[31:2], 2'b00};
                            mem_be_q    <= be_d;
                            mem_wdata_q <= wdata_d;
                            off_q       <= addr[1:0];
                            ltype_q     <= LoadType;
                            is_read_q   <= ~is_write;
                        end else begin
                            misalign_q  <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    // An ack on the terminal-count cycle still counts as success.
                    if (mem.mem_ack) begin
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                        if (is_read_q) begin
                            rdata_q       <= load_d;
                            rdata_valid_q <= 1'b1;
                        end
                    end else if (cnt_q == '0) begin
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                        bus_err_q <= 1'b1;
                        if (is_read_q) begin
                            rdata_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stall         = rst_n && (((state_q == IDLE) && req && aligned) || (state_q == BUSY));
    assign rdata         = rdata_q;
    assign rdata_valid   = rdata_valid_q;
    assign misalign      = misalign_q;
    assign bus_err       = bus_err_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stimulus pushes expected memory
// transactions and pipeline responses; a monitor pops and compares them.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        MemRead;
    logic [1:0]  MemWrite;
    logic [2:0]  LoadType;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        misalign;
    logic        bus_err;

    mem_access_unit_if mif ();

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .LoadType    (LoadType),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .misalign    (misalign),
        .bus_err     (bus_err),
        .mem         (mif)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
    } txn_t;

    localparam int EV_MISALIGN = 1;
    localparam int EV_BUSERR   = 2;

    txn_t        exp_txn[$];
    logic [31:0] exp_rd[$];
    int          exp_evt[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event seen with nothing expected", name);
    endtask

    // Monitor: compares every DUT-presented event against the scoreboard.
    initial begin
        txn_t t;
        int   ev;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && mif.mem_req && mif.mem_ack) begin
                if (exp_txn.size() == 0) unexpected("mem_txn");
                else begin
                    t = exp_txn.pop_front();
                    chk("txn_we", {31'd0, mif.mem_we}, {31'd0, t.we});
                    chk("txn_addr", mif.mem_addr, t.a);
                    chk("txn_be", {28'd0, mif.mem_be}, {28'd0, t.be});
                    if (t.we) chk("txn_wdata", mif.mem_wdata, t.wd);
                end
            end
            if (rdata_valid) begin
                if (exp_rd.size() == 0) unexpected("rdata_valid");
                else chk("rdata", rdata, exp_rd.pop_front());
            end
            if (misalign) begin
                if (exp_evt.size() == 0) unexpected("misalign");
                else begin
                    ev = exp_evt.pop_front();
                    chk("evt_misalign", EV_MISALIGN, ev);
                end
            end
            if (bus_err) begin
                if (exp_evt.size() == 0) unexpected("bus_err");
                else begin
                    ev = exp_evt.pop_front();
                    chk("evt_bus_err", EV_BUSERR, ev);
                end
            end
        end
    end

    // Issue one request; ack_after = BUSY cycles before ack (-1: never ack).
    task automatic run_op(input logic rd, input logic [1:0] wr, input logic [2:0] lt,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                          input int ack_after, output int stall_cyc, output int req_cyc);
        int busy_n;
        MemRead   = rd;
        MemWrite  = wr;
        LoadType  = lt;
        addr      = a;
        wdata     = wd;
        mif.mem_rdata = rw;
        stall_cyc = 0;
        req_cyc   = 0;
        busy_n    = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (stall) stall_cyc++;
            if (mif.mem_req) begin
                req_cyc++;
                mif.mem_ack = (ack_after >= 0) && (busy_n == ack_after);
                busy_n++;
            end
            @(posedge clk);
            #1;
            mif.mem_ack = 1'b0;
            if (c == 0) begin
                MemRead  = 1'b0;
                MemWrite = 2'b00;
            end
        end
    endtask

    task automatic op_chk(input string name, input int stall_cyc, input int req_cyc,
                          input int exp_stall, input int exp_req);
        chk({name, "_stall_cycles"}, stall_cyc, exp_stall);
        chk({name, "_req_cycles"}, req_cyc, exp_req);
    endtask

    initial begin
        int s, r;
        rst_n = 1'b0;
        MemRead = 1'b0;
        MemWrite = 2'b00;
        LoadType = 3'b001;
        addr = '0;
        wdata = '0;
        mif.mem_ack = 1'b0;
        mif.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_flags", {29'd0, rdata_valid, misalign, bus_err}, 32'd0);
        chk("rst_req_we", {30'd0, mif.mem_req, mif.mem_we}, 32'd0);
        chk("rst_be", {28'd0, mif.mem_be}, 32'd0);
        chk("rst_addr", mif.mem_addr, 32'd0);
        chk("rst_wdata", mif.mem_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // SB at 0x103
        exp_txn.push_back('{we: 1'b1, a: 32'h100, be: 4'b1000, wd: 32'hABABABAB});
        run_op(1'b0, 2'b11, 3'b001, 32'h103, 32'h000000AB, 32'h0, 0, s, r);
        op_chk("sb", s, r, 2, 1);

        // LH / LHU / LTH at 0x22
        exp_txn.push_back('{we: 1'b0, a: 32'h20, be: 4'b1100, wd: 32'h0});
        exp_rd.push_back(32'hFFFF8001);
        run_op(1'b1, 2'b00, 3'b011, 32'h22, 32'h0, 32'h80011234, 0, s, r);
        op_chk("lh", s, r, 2, 1);
        exp_txn.push_back('{we: 1'b0, a: 32'h20, be: 4'b1100, wd: 32'h0});
        exp_rd.push_back(32'h00008001);
        run_op(1'b1, 2'b00, 3'b101, 32'h22, 32'h0, 32'h80011234, 0, s, r);
        exp_txn.push_back('{we: 1'b0, a: 32'h20, be: 4'b1100, wd: 32'h0});
        exp_rd.push_back(32'h80010000);
        run_op(1'b1, 2'b00, 3'b010, 32'h22, 32'h0, 32'h80011234, 0, s, r);

        // misaligned LW at 0x06
        exp_evt.push_back(EV_MISALIGN);
        run_op(1'b1, 2'b00, 3'b001, 32'h06, 32'h0, 32'h0, 0, s, r);
        op_chk("lw_misalign", s, r, 0, 0);

        // timeout with no ack: 4 request cycles
        exp_evt.push_back(EV_BUSERR);
        run_op(1'b0, 2'b01, 3'b001, 32'h10, 32'h12345678, 32'h0, -1, s, r);
        op_chk("timeout", s, r, 5, 4);
        chk("timeout_stall_released", {31'd0, stall}, 32'd0);

        // read and write together: write wins, rdata holds the LTH result
        exp_txn.push_back('{we: 1'b1, a: 32'h08, be: 4'b1111, wd: 32'hCAFEF00D});
        run_op(1'b1, 2'b01, 3'b011, 32'h08, 32'hCAFEF00D, 32'h0, 0, s, r);
        op_chk("rw_both", s, r, 2, 1);
        chk("rdata_hold", rdata, 32'h80010000);

        // LB lane 3 with a 2-cycle ack delay, LBU lane 1
        exp_txn.push_back('{we: 1'b0, a: 32'h20, be: 4'b1000, wd: 32'h0});
        exp_rd.push_back(32'hFFFFFF80);
        run_op(1'b1, 2'b00, 3'b100, 32'h23, 32'h0, 32'h80011234, 2, s, r);
        op_chk("lb_delay", s, r, 4, 3);
        exp_txn.push_back('{we: 1'b0, a: 32'h20, be: 4'b0010, wd: 32'h0});
        exp_rd.push_back(32'h00000012);
        run_op(1'b1, 2'b00, 3'b110, 32'h21, 32'h0, 32'h80011234, 0, s, r);

        // SH upper half, LH misaligned
        exp_txn.push_back('{we: 1'b1, a: 32'h00, be: 4'b1100, wd: 32'hBEEFBEEF});
        run_op(1'b0, 2'b10, 3'b001, 32'h02, 32'h1234BEEF, 32'h0, 0, s, r);
        exp_evt.push_back(EV_MISALIGN);
        run_op(1'b1, 2'b00, 3'b011, 32'h21, 32'h0, 32'h0, 0, s, r);

        // ack on the terminal-count cycle is a success
        exp_txn.push_back('{we: 1'b0, a: 32'h30, be: 4'b1111, wd: 32'h0});
        exp_rd.push_back(32'h11223344);
        run_op(1'b1, 2'b00, 3'b001, 32'h30, 32'h0, 32'h11223344, 3, s, r);
        op_chk("ack_at_tc", s, r, 5, 4);

        // undefined LoadType behaves as lw
        exp_txn.push_back('{we: 1'b0, a: 32'h04, be: 4'b1111, wd: 32'h0});
        exp_rd.push_back(32'h55AA55AA);
        run_op(1'b1, 2'b00, 3'b000, 32'h04, 32'h0, 32'h55AA55AA, 0, s, r);

        // reset during BUSY
        MemRead = 1'b1;
        LoadType = 3'b001;
        addr = 32'h40;
        @(posedge clk);
        #1;
        MemRead = 1'b0;
        @(negedge clk);
        chk("busy_req_before_rst", {31'd0, mif.mem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy_req", {31'd0, mif.mem_req}, 32'd0);
        chk("rst_mid_busy_stall", {31'd0, stall}, 32'd0);
        chk("rst_mid_busy_rdata", rdata, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        mif.mem_rdata = 32'h99999999;
        mif.mem_ack = 1'b1;
        @(posedge clk);
        #1;
        mif.mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_rdata", rdata, 32'd0);

        exp_txn.push_back('{we: 1'b0, a: 32'h40, be: 4'b1111, wd: 32'h0});
        exp_rd.push_back(32'hDEADBEEF);
        run_op(1'b1, 2'b00, 3'b001, 32'h40, 32'h0, 32'hDEADBEEF, 0, s, r);
        op_chk("after_rst", s, r, 2, 1);

        repeat (3) @(posedge clk);
        chk("pending_txn", exp_txn.size(), 32'd0);
        chk("pending_rdata", exp_rd.size(), 32'd0);
        chk("pending_evt", exp_evt.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset (rst_n), as already decided.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles to wait for mem_ack before abort.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 MemRead  input  1  load request from control.
REQ-006 MemWrite  input  2  00 none, 01 word, 10 half, 11 byte.
REQ-007 LoadType  input  3  001 lw, 010 LTH, 011 lh, 100 lb, 101 lhu, 110 lbu; other values are treated as lw when MemRead=1.
REQ-008 addr  input  32  byte address (ALU result).
REQ-009 wdata  input  32  store data, right-justified.
REQ-010 stall  output  1  freeze pipeline; feeds control stall.
REQ-011 rdata  output  32  formatted load result.
REQ-012 rdata_valid  output  1  one-cycle pulse: rdata is valid.
REQ-013 misalign  output  1  one-cycle pulse: request rejected for misalignment.
REQ-014 bus_err  output  1  one-cycle pulse: request aborted on timeout.
REQ-015 mem_req  output  1  backing-memory request; held high until ack.
REQ-016 mem_we  output  1  1 = write.
REQ-017 mem_addr  output  32  word address, {addr[31:2],2'b00}.
REQ-018 mem_be  output  4  byte lane enables; lane 0 = bits 7:0 (little-endian).
REQ-019 mem_wdata  output  32  lane-replicated store data.
REQ-020 mem_ack  input  1  backing memory done; valid only while mem_req=1.
REQ-021 mem_rdata  input  32  read word; valid when mem_ack=1 and mem_we=0.

Function
REQ-022 FSM states SHALL be IDLE, BUSY and DONE.
REQ-023 IDLE: a request is MemWrite!=00 or MemRead=1. If both are asserted, the write SHALL win and the read SHALL be ignored.
REQ-024 Alignment rules:
- word: addr[1:0]=00.
- half (SH, LH, LHU, LTH): addr[0]=0.
- byte: any address.
REQ-025 Aligned request in IDLE: the block SHALL latch addr, wdata, op and LoadType, assert stall combinationally in the same cycle, and enter BUSY.
REQ-026 Misaligned request in IDLE: misalign SHALL pulse in the next cycle, with no mem_req, no stall and the FSM staying in IDLE.
REQ-027 BUSY: mem_req=1, and mem_addr, mem_we, mem_be and mem_wdata SHALL be stable from latched values; stall=1.
REQ-028 Byte enables (o = latched addr[1:0]):
- word: be=1111.
- half: be=0011<<o.
- byte: be=0001<<o.
- reads drive be as for the load size.
REQ-029 mem_wdata:
- word: wdata.
- half: {2{wdata[15:0]}}.
- byte: {4{wdata[7:0]}}.
REQ-030 BUSY with mem_ack=1: the FSM SHALL go to DONE. For reads, rdata SHALL be registered from mem_rdata.
REQ-031 Load formatting, with h = half at lane o[1] and b = byte at lane o:
- lh: sign-extend h.
- lhu: zero-extend h.
- lb: sign-extend b.
- lbu: zero-extend b.
- LTH: {h,16'h0000}.
- lw: the full word.
REQ-032 DONE lasts exactly one cycle, then the FSM SHALL return to IDLE:
- stall=0.
- mem_req=0.
- rdata_valid=1 for reads only.
- Requests presented during DONE are ignored.
REQ-033 A counter SHALL count cycles in BUSY. If it reaches TIMEOUT without mem_ack:
- mem_req drops, bus_err pulses and the FSM enters DONE.
- For reads, rdata SHALL be 0 and rdata_valid=0.
REQ-034 An ack arriving in the same cycle the counter reaches TIMEOUT SHALL count as success.
REQ-035 rdata SHALL hold its last value until the next successful read.
REQ-036 Minimum request latency (ack in the first BUSY cycle): stall is high for 2 cycles, IDLE plus BUSY.

Reset
REQ-037 rst_n=0 SHALL immediately force the following, with no pending request retained:
- state IDLE.
- stall, mem_req, mem_we, rdata_valid, misalign and bus_err = 0.
- mem_be = 0000.
- mem_addr, mem_wdata and rdata = 0.
- counter = 0.
REQ-038 Reset asserted mid-BUSY SHALL drop mem_req asynchronously. A mem_ack arriving afterwards SHALL be ignored.

Verification
REQ-039 The bench SHALL cover SB: addr=0x103, wdata=0xAB, ack after 1 cycle -> mem_addr=0x100, be=1000, mem_wdata=0xABABABAB, stall high 2 cycles, no rdata_valid.
REQ-040 The bench SHALL cover LH: addr=0x22, mem_rdata=0x8001_1234 -> rdata=0xFFFF8001, rdata_valid 1 cycle. LHU on the same inputs -> 0x00008001. LTH on the same inputs -> 0x80010000.
REQ-041 The bench SHALL cover LW at addr=0x06 -> misalign pulse, mem_req never rises, stall stays 0.
REQ-042 The bench SHALL cover a timeout with TIMEOUT=4 and mem_ack tied low -> mem_req high 4 cycles, bus_err pulse, return to IDLE, stall released.
REQ-043 The bench SHALL cover MemRead=1 with MemWrite=01 simultaneously -> write performed (mem_we=1, be=1111), no rdata_valid.
REQ-044 The bench SHALL cover rst_n low during BUSY -> mem_req=0 the same cycle. A later mem_ack causes no rdata_valid. The next request proceeds normally.
